// File: rtl/fx2_stream_in_if.sv
// Source-side stream handshake for fx2_stream_in: one word per s_valid & s_ready
// cycle, with s_last marking the final word of a transfer.
interface fx2_stream_in_if #(
    parameter int DATA_W = 8
) ();
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_last;
    logic              s_ready;

    // Producer of words (drives data/valid/last, observes ready).
    modport master (
        output s_data,
        output s_valid,
        output s_last,
        input  s_ready
    );

    // Consumer of words (the FX2 writer).
    modport slave (
        input  s_data,
        input  s_valid,
        input  s_last,
        output s_ready
    );
endinterface

// File: rtl/fx2_stream_in.sv
// fx2_stream_in: moves a source word stream into a Cypress FX2 slave FIFO
// (synchronous mode, IFCLK driven from clk). Each accepted word takes three
// cycles: accept, set up the bus, strobe SLWR. Full packets are committed by the
// FX2 itself; short packets (s_last or an idle timeout) are committed with a
// one-cycle PKTEND strobe. pkt_done pulses on every commit.
module fx2_stream_in #(
    parameter int         DATA_W       = 8,
    parameter int         PKT_LEN      = 512,
    parameter logic [1:0] EP_ADDR      = 2'b10,
    parameter int         IDLE_TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              reset,
    output logic              clk_out,
    fx2_stream_in_if.slave    src,
    input  logic              full_n,
    output logic [DATA_W-1:0] fdata,
    output logic [1:0]        faddr,
    output logic              sloe,
    output logic              slrd,
    output logic              slwr,
    output logic              pkt_end,
    output logic              pkt_done,
    output logic [10:0]       word_cnt
);

    // Idle counter is wide enough to reach IDLE_TIMEOUT and then holds there.
    localparam int              IDLE_W    = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT + 1) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LIM  = IDLE_W'(IDLE_TIMEOUT);
    localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);
    localparam logic              IDLE_ON   = (IDLE_TIMEOUT != 0);
    localparam logic [10:0]       PKT_LEN_W = 11'(PKT_LEN);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_ROOM = 3'd1,
        SETUP     = 3'd2,
        WRITE     = 3'd3,
        PKTEND    = 3'd4
    } state_t;

    state_t            state;
    logic              last_word;
    logic [IDLE_W-1:0] idle_cnt;
    logic              accept;
    logic              timeout;
    logic              idle_grow;
    logic [10:0]       word_cnt_inc;

    // The FX2 side of the bus is write-only towards a fixed endpoint.
    assign clk_out      = clk;
    assign faddr        = EP_ADDR;
    assign sloe         = 1'b1;
    assign slrd         = 1'b1;
    assign src.s_ready  = accept;
    assign word_cnt_inc = word_cnt + 11'd1;

    // Acceptance, idle-count and timeout decisions for the current WAIT_ROOM cycle.
    always_comb begin
        accept    = 1'b0;
        timeout   = 1'b0;
        idle_grow = 1'b0;
        if (!reset && (state == WAIT_ROOM)) begin
            accept    = src.s_valid && full_n;
            // An arriving word always beats a pending timeout.
            timeout   = IDLE_ON && (idle_cnt == IDLE_LIM) && (word_cnt != 11'd0)
                        && !(src.s_valid && full_n);
            // Only a started packet ages; a full FIFO freezes the count.
            idle_grow = IDLE_ON && (word_cnt != 11'd0) && !src.s_valid && full_n
                        && (idle_cnt != IDLE_LIM);
        end else begin
            accept    = 1'b0;
            timeout   = 1'b0;
            idle_grow = 1'b0;
        end
    end

    // Write FSM; strobes are registered from the state being entered so that
    // slwr/pkt_end are low exactly while the FSM sits in WRITE/PKTEND.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            slwr      <= 1'b1;
            pkt_end   <= 1'b1;
            pkt_done  <= 1'b0;
            fdata     <= '0;
            word_cnt  <= 11'd0;
            idle_cnt  <= '0;
            last_word <= 1'b0;
        end else begin
            slwr     <= 1'b1;
            pkt_end  <= 1'b1;
            pkt_done <= 1'b0;
            case (state)
                IDLE: begin
                    state <= WAIT_ROOM;
                end
                WAIT_ROOM: begin
                    if (accept) begin
                        fdata     <= src.s_data;
                        last_word <= src.s_last;
                        idle_cnt  <= '0;
                        state     <= SETUP;
                    end else if (timeout) begin
                        idle_cnt <= '0;
                        pkt_end  <= 1'b0;
                        pkt_done <= 1'b1;
                        state    <= PKTEND;
                    end else begin
                        if (idle_grow) begin
                            idle_cnt <= idle_cnt + IDLE_ONE;
                        end else begin
                            idle_cnt <= idle_cnt;
                        end
                        state <= WAIT_ROOM;
                    end
                end
                SETUP: begin
                    // fdata has been stable for a cycle; strobe it next.
                    slwr  <= 1'b0;
                    state <= WRITE;
                end
                WRITE: begin
                    if (word_cnt_inc == PKT_LEN_W) begin
                        // Full packet: the FX2 auto-commits, even if s_last was set.
                        word_cnt <= 11'd0;
                        idle_cnt <= '0;
                        pkt_done <= 1'b1;
                        state    <= WAIT_ROOM;
                    end else if (last_word) begin
                        word_cnt <= word_cnt_inc;
                        pkt_end  <= 1'b0;
                        pkt_done <= 1'b1;
                        state    <= PKTEND;
                    end else begin
                        word_cnt <= word_cnt_inc;
                        state    <= WAIT_ROOM;
                    end
                end
                PKTEND: begin
                    word_cnt <= 11'd0;
                    idle_cnt <= '0;
                    state    <= WAIT_ROOM;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/fx2_stream_in.md
FX2_STREAM_IN -- requirements
Module: fx2_stream_in

Interface
REQ-001 SHALL have parameter DATA_W, default 8, FX2 slave-FIFO bus width (legal values 8 or 16).
REQ-002 SHALL have parameter PKT_LEN, default 512, words per full USB packet (legal range 2..1024).
REQ-003 SHALL have parameter EP_ADDR, default 2'b10, FIFOADR code of the target endpoint (EP6).
REQ-004 SHALL have parameter IDLE_TIMEOUT, default 1024, idle cycles before a partial packet is committed; 0 disables the timeout.
REQ-005 SHALL have port clk  input  1  single clock for all logic; one clock; reset is synchronous and active-high.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port clk_out  output  1  equal to clk, drives the FX2 IFCLK.
REQ-008 SHALL have port s_data  input  DATA_W  source word.
REQ-009 SHALL have port s_valid  input  1  source word present.
REQ-010 SHALL have port s_last  input  1  word ends a transfer; qualified by s_valid.
REQ-011 SHALL have port s_ready  output  1  word accepted this cycle.
REQ-012 SHALL have port full_n  input  1  FX2 target-FIFO full flag, low = full.
REQ-013 SHALL have port fdata  output  DATA_W  FX2 data bus.
REQ-014 SHALL have port faddr  output  2  constant EP_ADDR.
REQ-015 SHALL have port sloe, slrd  output  1 each  constant 1.
REQ-016 SHALL have port slwr  output  1  active-low write strobe, registered.
REQ-017 SHALL have port pkt_end  output  1  active-low short-packet commit, registered.
REQ-018 SHALL have port pkt_done  output  1  one-cycle high pulse on every packet commit (full or short).
REQ-019 SHALL have port word_cnt  output  11  words written into the current packet.

Function
REQ-020 SHALL implement states IDLE, WAIT_ROOM, SETUP, WRITE, PKTEND.
REQ-021 SHALL transition IDLE -> WAIT_ROOM unconditionally.
REQ-022 In WAIT_ROOM, s_ready SHALL equal s_valid & full_n; on acceptance, s_data and s_last SHALL be latched and the next state SHALL be SETUP; otherwise the FSM SHALL stay in WAIT_ROOM.
REQ-023 s_ready SHALL be 0 in every state other than WAIT_ROOM.
REQ-024 SETUP SHALL drive the latched word on fdata and go to WRITE; fdata SHALL hold that word until the next acceptance.
REQ-025 slwr SHALL be 0 for exactly the one cycle the FSM is in WRITE (registered from next_state), i.e. 2 cycles after the acceptance cycle; maximum throughput is one word per 3 cycles.
REQ-026 At the end of WRITE, word_cnt SHALL increment; if it reaches PKT_LEN, word_cnt SHALL clear to 0, pkt_done SHALL pulse, pkt_end SHALL stay 1 (FX2 auto-commit), and the next state SHALL be WAIT_ROOM.
REQ-027 If the written word had s_last=1 and word_cnt+1 < PKT_LEN, the next state SHALL be PKTEND.
REQ-028 s_last on the word that completes PKT_LEN SHALL be treated as a full packet: no pkt_end.
REQ-029 PKTEND SHALL assert pkt_end=0 for exactly one cycle, pulse pkt_done, clear word_cnt, and return to WAIT_ROOM.
REQ-030 The idle counter SHALL increment in WAIT_ROOM while word_cnt>0, s_valid=0 and full_n=1, and SHALL clear on any acceptance or commit.
REQ-031 When the idle counter equals IDLE_TIMEOUT (IDLE_TIMEOUT>0), the FSM SHALL go to PKTEND.
REQ-032 With word_cnt=0 no timeout SHALL fire; zero-length packets SHALL never be issued.
REQ-033 full_n=0 SHALL block acceptance indefinitely and freeze the idle counter.
REQ-034 If s_valid and the timeout coincide, acceptance SHALL win.

Reset
REQ-035 During reset: state=IDLE, slwr=1, pkt_end=1, pkt_done=0, s_ready=0, fdata=0, word_cnt=0, idle counter=0.
REQ-036 Reset asserted mid-packet SHALL abandon the partial packet without pulsing pkt_end; slwr SHALL be 1 on the cycle after reset is sampled.

Verification
REQ-037 Stream 512 words (DATA_W=8) with s_valid constantly high and full_n=1 -> 512 slwr pulses spaced 3 cycles apart, one pkt_done, pkt_end never low.
REQ-038 5 words with s_last on the 5th -> 5 slwr pulses, pkt_end low for 1 cycle, 1 cycle after the 5th slwr; word_cnt back to 0.
REQ-039 IDLE_TIMEOUT=8: 3 words, then s_valid=0 -> pkt_end low after 8 idle cycles; no further pkt_end while idle.
REQ-040 full_n held 0 for 20 cycles with s_valid=1 -> s_ready=0 and slwr=1 throughout; first write 2 cycles after full_n rises.
REQ-041 Reset pulsed 1 cycle after a WRITE at word_cnt=100 -> all outputs at reset values, no pkt_end; next packet starts from word_cnt=0.
REQ-042 DATA_W=16, PKT_LEN=256, s_last on word 256 -> fdata carries 16-bit words, pkt_done pulses, pkt_end stays 1.
